// File: rtl/vga_scan_out.sv
// 640x480@60 VGA raster sink: free-running h/v counters, one pixel pulled per
// active cycle, single registered output stage to the DAC and sync pins.
module vga_scan_out #(
  parameter int pixel_bits_p = 4,
  parameter int h_active_p   = 640,
  parameter int h_front_p    = 16,
  parameter int h_sync_p     = 96,
  parameter int h_back_p     = 48,
  parameter int v_active_p   = 480,
  parameter int v_front_p    = 10,
  parameter int v_sync_p     = 2,
  parameter int v_back_p     = 33
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         valid_i,
  input  logic [2:0][pixel_bits_p-1:0] data_i,
  output logic                         ready_o,
  output logic [2:0][pixel_bits_p-1:0] rgb_o,
  output logic                         hsync_o,
  output logic                         vsync_o,
  output logic                         frame_o,
  output logic                         underflow_o
);

  localparam int H_TOTAL = h_active_p + h_front_p + h_sync_p + h_back_p;
  localparam int V_TOTAL = v_active_p + v_front_p + v_sync_p + v_back_p;

  localparam logic [9:0] H_ACT  = 10'(h_active_p);
  localparam logic [9:0] H_SS   = 10'(h_active_p + h_front_p);
  localparam logic [9:0] H_SE   = 10'(h_active_p + h_front_p + h_sync_p);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT  = 10'(v_active_p);
  localparam logic [9:0] V_SS   = 10'(v_active_p + v_front_p);
  localparam logic [9:0] V_SE   = 10'(v_active_p + v_front_p + v_sync_p);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic [9:0]                   h_q, h_d, v_q, v_d;
  logic                         active, h_wrap;
  logic [2:0][pixel_bits_p-1:0] rgb_q, rgb_d;
  logic                         hsync_q, hsync_d, vsync_q, vsync_d;
  logic                         frame_q, frame_d, underflow_q, underflow_d;

  always_comb begin
    active      = (h_q < H_ACT) && (v_q < V_ACT);
    h_wrap      = (h_q == H_LAST);
    h_d         = h_wrap ? '0 : h_q + 10'd1;
    v_d         = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
    // A starved active pixel goes out black; the source still advances.
    rgb_d       = (active && valid_i) ? data_i : '0;
    hsync_d     = !((h_q >= H_SS) && (h_q < H_SE));
    vsync_d     = !((v_q >= V_SS) && (v_q < V_SE));
    frame_d     = (h_q == '0) && (v_q == '0);
    underflow_d = underflow_q | (active & ~valid_i);
  end

  // Gated by reset so the source never sees a pull while the raster is held.
  assign ready_o = active & reset_ni;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      h_q         <= '0;
      v_q         <= '0;
      rgb_q       <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      frame_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      frame_q     <= frame_d;
      underflow_q <= underflow_d;
    end
  end

  assign rgb_o       = rgb_q;
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign frame_o     = frame_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Scoreboard bench for vga_scan_out on a shrunken raster; expected outputs are
// derived from an elapsed-cycle count (x = t mod H, y = (t div H) mod V).
module tb_vga_scan_out;

  localparam int PB = 4;
  localparam int DW = 3 * PB;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic               clk_i    = 1'b0;
  logic               reset_ni = 1'b1;
  logic               valid_i  = 1'b0;
  logic [2:0][PB-1:0] data_i   = '0;
  logic               ready_o;
  logic [2:0][PB-1:0] rgb_o;
  logic               hsync_o, vsync_o, frame_o, underflow_o;

  vga_scan_out #(
    .pixel_bits_p(PB),
    .h_active_p(HA), .h_front_p(HF), .h_sync_p(HS), .h_back_p(HB),
    .v_active_p(VA), .v_front_p(VF), .v_sync_p(VS), .v_back_p(VB)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .rgb_o(rgb_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .frame_o(frame_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int rgb; int hs; int vs; int fr; int uf; } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;
  int t = 0;
  int uf_m = 0;
  int drop_x = -1;
  int drop_y = -1;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at time %0t", nm, act, req, $time);
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.rgb = 0; e.hs = 1; e.vs = 1; e.fr = 0; e.uf = 0;
    return e;
  endfunction

  // One raster cycle, entered and left on a falling edge.
  // mode 0: always valid while active, random valid in blanking; mode 1: random.
  task automatic step(input int mode);
    int   x, y;
    bit   act, vld;
    exp_t e;
    x   = t % HT;
    y   = (t / HT) % VT;
    act = (x < HA) && (y < VA);
    if (mode == 0) vld = act ? 1'b1 : 1'(($urandom_range(0, 1)));
    else           vld = ($urandom_range(0, 7) != 0);
    if (x == drop_x && y == drop_y) vld = 1'b0;
    valid_i = vld;
    data_i  = DW'($urandom);
    #1;
    chk("ready", int'(ready_o), int'(act));
    if (act && !vld) uf_m = 1;
    e.rgb = (act && vld) ? int'(data_i) : 0;
    e.hs  = (x >= HA + HF && x < HA + HF + HS) ? 0 : 1;
    e.vs  = (y >= VA + VF && y < VA + VF + VS) ? 0 : 1;
    e.fr  = (x == 0 && y == 0) ? 1 : 0;
    e.uf  = uf_m;
    sb.push_back(e);
    t++;
    @(negedge clk_i);
  endtask

  // Monitor: every registered output is checked one edge after its stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rgb",       int'(rgb_o),       e.rgb);
        chk("hsync",     int'(hsync_o),     e.hs);
        chk("vsync",     int'(vsync_o),     e.vs);
        chk("frame",     int'(frame_o),     e.fr);
        chk("underflow", int'(underflow_o), e.uf);
      end
    end
  end

  initial begin
    int guard;
    #1 reset_ni = 1'b0;
    valid_i = 1'b1;
    @(negedge clk_i);
    repeat (5) begin
      data_i = DW'($urandom);
      #1;
      chk("rst_ready", int'(ready_o), 0);
      sb.push_back(reset_exp());
      @(negedge clk_i);
    end

    reset_ni = 1'b1;
    t = 0;
    uf_m = 0;
    repeat (2 * HT * VT) step(0);

    drop_x = 5; drop_y = 2;
    repeat (HT * VT) step(0);
    drop_x = -1; drop_y = -1;
    repeat (HT * VT) step(1);

    guard = 0;
    while (!((t % HT) == 10 && ((t / HT) % VT) == 3) && guard < 2 * HT * VT) begin
      step(1);
      guard++;
    end
    chk("reach_reset_point", t % HT + 100 * ((t / HT) % VT), 310);

    valid_i = 1'b1;
    data_i  = DW'($urandom);
    #2 reset_ni = 1'b0;
    #1;
    chk("async_ready", int'(ready_o),     0);
    chk("async_rgb",   int'(rgb_o),       0);
    chk("async_hsync", int'(hsync_o),     1);
    chk("async_vsync", int'(vsync_o),     1);
    chk("async_frame", int'(frame_o),     0);
    chk("async_uf",    int'(underflow_o), 0);
    sb.delete();
    uf_m = 0;
    repeat (3) begin
      sb.push_back(reset_exp());
      @(negedge clk_i);
    end

    reset_ni = 1'b1;
    t = 0;
    repeat (HT * VT + HT) step(0);

    repeat (2) @(negedge clk_i);
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
